// File: rtl/post_spi_pkg.sv
// Shared types and constants for the Post-machine SPI initiator.
// Purely declarative: no latency, no flow control.
// Frame width is fixed at 8 bits; bus mode is SPI mode 0.
package post_spi_pkg;

    localparam int FRAME_W = 8;
    localparam bit CPOL    = 1'b0;
    localparam bit CPHA    = 1'b0;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; (1 << i) < value; i++) begin
            r = i + 1;
        end
        return r;
    endfunction

    // One count per SCK transition: two per bit.
    localparam int BIT_CNT_W = clog2(FRAME_W * 2);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_GAP,
        ST_HOLD,
        ST_DESEL
    } state_t;

endpackage

// File: rtl/post_spi_tick.sv
// Half-period tick generator for the SPI initiator.
// Tick fires CLK_DIV cycles after enable rises, then every CLK_DIV cycles.
// No backpressure: counter reloads whenever en is low.
module post_spi_tick #(
    parameter int CLK_DIV = 4
) (
    input  logic CLK,
    input  logic NRST,
    input  logic en,
    output logic tick
);

    localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] cnt;

    assign tick = en && (cnt == '0);

    always_ff @(posedge CLK or negedge NRST) begin
        if (!NRST) begin
            cnt <= '0;
        end else if (!en || tick) begin
            cnt <= RELOAD;
        end else begin
            cnt <= cnt - 1'b1;
        end
    end

endmodule

// File: rtl/post_spi_master.sv
// SPI mode-0 initiator with a byte valid/ready interface; CS held across a burst until LAST.
// Latency: accept to RX_VALID is 16*CLK_DIV cycles; single-byte transaction is 18*CLK_DIV to next ready.
// TX_READY only in IDLE and GAP; TX_VALID elsewhere is ignored, not queued.
module post_spi_master #(
    parameter int CLK_DIV = 4,
    parameter int FRAME_W = 8
) (
    input  logic               CLK,
    input  logic               NRST,
    input  logic [FRAME_W-1:0] TX_DATA,
    input  logic               TX_LAST,
    input  logic               TX_VALID,
    output logic               TX_READY,
    output logic [FRAME_W-1:0] RX_DATA,
    output logic               RX_VALID,
    output logic               BUSY,
    output logic               SPI_SCK,
    output logic               SPI_MOSI,
    output logic               SPI_CS,
    input  logic               SPI_MISO
);

    import post_spi_pkg::*;

    localparam logic [BIT_CNT_W-1:0] LAST_EDGE = BIT_CNT_W'(2 * FRAME_W - 1);

    state_t               state;
    logic [FRAME_W-1:0]   tx_sh;
    logic [FRAME_W-1:0]   rx_sh;
    logic                 last_q;
    logic [BIT_CNT_W-1:0] edge_cnt;
    logic                 tick_en;
    logic                 tick;

    assign tick_en  = (state == ST_SHIFT) || (state == ST_HOLD) || (state == ST_DESEL);
    assign TX_READY = (state == ST_IDLE) || (state == ST_GAP);
    assign BUSY     = (state != ST_IDLE);

    post_spi_tick #(
        .CLK_DIV (CLK_DIV)
    ) u_tick (
        .CLK  (CLK),
        .NRST (NRST),
        .en   (tick_en),
        .tick (tick)
    );

    always_ff @(posedge CLK or negedge NRST) begin
        if (!NRST) begin
            state    <= ST_IDLE;
            tx_sh    <= '0;
            rx_sh    <= '0;
            last_q   <= 1'b0;
            edge_cnt <= '0;
            SPI_CS   <= 1'b1;
            SPI_SCK  <= CPOL;
            SPI_MOSI <= 1'b0;
            RX_DATA  <= '0;
            RX_VALID <= 1'b0;
        end else begin
            RX_VALID <= 1'b0;
            case (state)
                ST_IDLE, ST_GAP: begin
                    if (TX_VALID) begin
                        tx_sh    <= TX_DATA;
                        last_q   <= TX_LAST;
                        SPI_CS   <= 1'b0;
                        SPI_MOSI <= TX_DATA[FRAME_W-1];
                        edge_cnt <= '0;
                        state    <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (tick) begin
                        SPI_SCK  <= ~SPI_SCK;
                        edge_cnt <= edge_cnt + 1'b1;
                        // Leaving the idle level is the sampling edge in mode 0.
                        if (SPI_SCK == (CPOL ^ CPHA)) begin
                            rx_sh <= {rx_sh[FRAME_W-2:0], SPI_MISO};
                        end else if (edge_cnt == LAST_EDGE) begin
                            RX_DATA  <= rx_sh;
                            RX_VALID <= 1'b1;
                            SPI_MOSI <= 1'b0;
                            state    <= last_q ? ST_HOLD : ST_GAP;
                        end else begin
                            tx_sh    <= tx_sh << 1;
                            SPI_MOSI <= tx_sh[FRAME_W-2];
                        end
                    end
                end
                ST_HOLD: begin
                    if (tick) begin
                        SPI_CS <= 1'b1;
                        state  <= ST_DESEL;
                    end
                end
                ST_DESEL: begin
                    if (tick) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_post_spi_master.sv
// Bench for post_spi_master: CLK_DIV=2 and CLK_DIV=1 instances share one mode-0 slave model.
// Scoreboard queues hold expected MOSI bytes (checked by the slave) and RX bytes (checked on RX_VALID).
module tb_post_spi_master;

    logic clk  = 1'b0;
    logic nrst = 1'b0;
    always #5 clk = ~clk;

    logic [7:0] tx_data  = 8'h00;
    logic       tx_last  = 1'b0;
    logic       tx_valid = 1'b0;
    logic       sel1     = 1'b0;
    logic       miso;

    logic       rdy2, rxv2, busy2, sck2, mosi2, cs2;
    logic [7:0] rxd2;
    logic       rdy1, rxv1, busy1, sck1, mosi1, cs1;
    logic [7:0] rxd1;

    post_spi_master #(.CLK_DIV(2)) dut (
        .CLK(clk), .NRST(nrst), .TX_DATA(tx_data), .TX_LAST(tx_last),
        .TX_VALID(tx_valid & ~sel1), .TX_READY(rdy2), .RX_DATA(rxd2), .RX_VALID(rxv2),
        .BUSY(busy2), .SPI_SCK(sck2), .SPI_MOSI(mosi2), .SPI_CS(cs2), .SPI_MISO(miso)
    );

    post_spi_master #(.CLK_DIV(1)) dut1 (
        .CLK(clk), .NRST(nrst), .TX_DATA(tx_data), .TX_LAST(tx_last),
        .TX_VALID(tx_valid & sel1), .TX_READY(rdy1), .RX_DATA(rxd1), .RX_VALID(rxv1),
        .BUSY(busy1), .SPI_SCK(sck1), .SPI_MOSI(mosi1), .SPI_CS(cs1), .SPI_MISO(miso)
    );

    logic       tx_ready, rx_vld, busy, sck, mosi, cs;
    logic [7:0] rx_dat;
    assign tx_ready = sel1 ? rdy1  : rdy2;
    assign rx_vld   = sel1 ? rxv1  : rxv2;
    assign rx_dat   = sel1 ? rxd1  : rxd2;
    assign busy     = sel1 ? busy1 : busy2;
    assign sck      = sel1 ? sck1  : sck2;
    assign mosi     = sel1 ? mosi1 : mosi2;
    assign cs       = sel1 ? cs1   : cs2;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_vec = 0;
    int n_err = 0;
    logic [7:0] exp_tx[$];
    logic [7:0] exp_rx[$];

    // Mode-0 slave: drives MSB first, response byte i of the current CS-low window.
    logic [7:0] sl_resp[0:3];
    logic [7:0] sl_sh = 8'h00;
    logic [7:0] sl_rx = 8'h00;
    int         sl_bits = 0;
    int         sl_idx  = 0;
    assign miso = sl_sh[7];

    always @(negedge cs) begin
        sl_idx  = 0;
        sl_bits = 0;
        sl_sh   = sl_resp[0];
    end

    always @(posedge cs) sl_bits = 0;

    always @(posedge sck) begin : slave_cap
        logic [7:0] e;
        if (!cs) begin
            sl_rx = {sl_rx[6:0], mosi};
            sl_bits++;
            if (sl_bits == 8) begin
                n_vec++;
                if (exp_tx.size() == 0) begin
                    n_err++;
                    $display("FAIL mosi_unexpected: slave got %02h, none expected", sl_rx);
                end else begin
                    e = exp_tx.pop_front();
                    if (sl_rx !== e) begin
                        n_err++;
                        $display("FAIL mosi_byte: slave got %02h, expected %02h", sl_rx, e);
                    end
                end
            end
        end
    end

    always @(negedge sck) begin
        if (!cs) begin
            if (sl_bits == 8) begin
                sl_bits = 0;
                if (sl_idx < 3) sl_idx++;
                sl_sh = sl_resp[sl_idx];
            end else begin
                sl_sh = {sl_sh[6:0], 1'b0};
            end
        end
    end

    always @(negedge clk) begin : rx_mon
        logic [7:0] e;
        if (nrst && rx_vld) begin
            n_vec++;
            if (exp_rx.size() == 0) begin
                n_err++;
                $display("FAIL rx_unexpected: RX_DATA=%02h, none expected", rx_dat);
            end else begin
                e = exp_rx.pop_front();
                if (rx_dat !== e) begin
                    n_err++;
                    $display("FAIL rx_byte: RX_DATA=%02h, expected %02h", rx_dat, e);
                end
            end
        end
    end

    // Observation window results (absolute cycle numbers, -1 = not seen).
    int w_rx_cnt, w_cs_falls, w_cs_rises, w_rises;
    int w_rx_first, w_cs_rise, w_rdy_rise, w_rise_first, w_rise_last;
    logic [7:0] w_mosi;

    task automatic watch(input int ncyc);
        logic p_cs, p_sck, p_rdy;
        w_rx_cnt = 0; w_cs_falls = 0; w_cs_rises = 0; w_rises = 0;
        w_rx_first = -1; w_cs_rise = -1; w_rdy_rise = -1; w_rise_first = -1; w_rise_last = -1;
        w_mosi = 8'h00;
        p_cs = cs; p_sck = sck; p_rdy = tx_ready;
        for (int i = 0; i < ncyc; i++) begin
            if (i > 0) @(negedge clk);
            if (rx_vld) begin
                w_rx_cnt++;
                if (w_rx_first < 0) w_rx_first = cyc;
            end
            if (p_cs && !cs) w_cs_falls++;
            if (!p_cs && cs) begin w_cs_rises++; w_cs_rise = cyc; end
            if (!p_sck && sck) begin
                w_rises++;
                w_mosi = {w_mosi[6:0], mosi};
                if (w_rise_first < 0) w_rise_first = cyc;
                w_rise_last = cyc;
            end
            if (!p_rdy && tx_ready && w_rdy_rise < 0) w_rdy_rise = cyc;
            p_cs = cs; p_sck = sck; p_rdy = tx_ready;
        end
    endtask

    // Called at a negedge; returns at the negedge following the accept edge.
    task automatic send_byte(input logic [7:0] d, input logic l, input logic [7:0] resp,
                             input bit hold, output int t0);
        int w;
        tx_data = d; tx_last = l; tx_valid = 1'b1; w = 0;
        while (tx_ready !== 1'b1 && w < 400) begin
            @(negedge clk);
            w++;
        end
        if (w >= 400) begin
            n_vec++; n_err++;
            $display("FAIL accept_timeout: TX_READY=%b after %0d cycles, expected 1", tx_ready, w);
            tx_valid = 1'b0;
            t0 = cyc;
            return;
        end
        @(posedge clk);
        @(negedge clk);
        t0 = cyc;
        exp_tx.push_back(d);
        exp_rx.push_back(resp);
        if (!hold) tx_valid = 1'b0;
    endtask

    task automatic test_reset;
        repeat (2) @(negedge clk);
        n_vec++; if (cs2 !== 1'b1)    begin n_err++; $display("FAIL rst_cs: %b, expected 1", cs2); end
        n_vec++; if (sck2 !== 1'b0)   begin n_err++; $display("FAIL rst_sck: %b, expected 0", sck2); end
        n_vec++; if (mosi2 !== 1'b0)  begin n_err++; $display("FAIL rst_mosi: %b, expected 0", mosi2); end
        n_vec++; if (rxd2 !== 8'h00)  begin n_err++; $display("FAIL rst_rxdata: %02h, expected 00", rxd2); end
        n_vec++; if (rxv2 !== 1'b0)   begin n_err++; $display("FAIL rst_rxvalid: %b, expected 0", rxv2); end
        n_vec++; if (busy2 !== 1'b0)  begin n_err++; $display("FAIL rst_busy: %b, expected 0", busy2); end
        n_vec++; if (rdy2 !== 1'b1)   begin n_err++; $display("FAIL rst_ready: %b, expected 1", rdy2); end
        n_vec++; if ({cs1, sck1, rdy1} !== 3'b101) begin n_err++; $display("FAIL rst_div1: cs/sck/rdy=%b, expected 101", {cs1, sck1, rdy1}); end
        nrst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single;
        int t0;
        sl_resp[0] = 8'h3C;
        send_byte(8'hA5, 1'b1, 8'h3C, 1'b0, t0);
        n_vec++; if ({cs, busy, mosi, tx_ready} !== 4'b0110) begin n_err++; $display("FAIL single_t0: cs/busy/mosi/rdy=%b, expected 0110", {cs, busy, mosi, tx_ready}); end
        watch(45);
        n_vec++; if (w_mosi !== 8'hA5)        begin n_err++; $display("FAIL single_mosi: %02h, expected a5", w_mosi); end
        n_vec++; if (w_rises !== 8)           begin n_err++; $display("FAIL single_rises: %0d, expected 8", w_rises); end
        n_vec++; if (w_rx_first - t0 !== 32)  begin n_err++; $display("FAIL single_rx_at: %0d, expected 32", w_rx_first - t0); end
        n_vec++; if (w_cs_rise - t0 !== 34)   begin n_err++; $display("FAIL single_cs_rise: %0d, expected 34", w_cs_rise - t0); end
        n_vec++; if (w_rdy_rise - t0 !== 36)  begin n_err++; $display("FAIL single_ready_at: %0d, expected 36", w_rdy_rise - t0); end
    endtask

    task automatic test_back_to_back;
        int ta, tb, tc;
        sl_resp[0] = 8'h81; sl_resp[1] = 8'h42; sl_resp[2] = 8'h24;
        ta = 0;
        fork
            watch(110);
            begin
                send_byte(8'h01, 1'b0, 8'h81, 1'b1, ta);
                send_byte(8'h02, 1'b0, 8'h42, 1'b1, tb);
                send_byte(8'h80, 1'b1, 8'h24, 1'b0, tc);
            end
        join
        n_vec++; if (w_cs_falls !== 1)        begin n_err++; $display("FAIL burst_cs_falls: %0d, expected 1", w_cs_falls); end
        n_vec++; if (w_cs_rises !== 1)        begin n_err++; $display("FAIL burst_cs_rises: %0d, expected 1", w_cs_rises); end
        n_vec++; if (w_cs_rise - ta !== 100)  begin n_err++; $display("FAIL burst_cs_rise_at: %0d, expected 100", w_cs_rise - ta); end
        n_vec++; if (w_rises !== 24)          begin n_err++; $display("FAIL burst_rises: %0d, expected 24", w_rises); end
        n_vec++; if (w_rx_cnt !== 3)          begin n_err++; $display("FAIL burst_rx_count: %0d, expected 3", w_rx_cnt); end
        n_vec++; if (tc - ta !== 66)          begin n_err++; $display("FAIL burst_third_accept: %0d, expected 66", tc - ta); end
    endtask

    task automatic test_gap_stall;
        int t0, t1, bad, nrdy;
        sl_resp[0] = 8'h0F; sl_resp[1] = 8'hF0;
        send_byte(8'h55, 1'b0, 8'h0F, 1'b0, t0);
        watch(34);
        n_vec++; if (w_rx_first - t0 !== 32)  begin n_err++; $display("FAIL gap_rx1_at: %0d, expected 32", w_rx_first - t0); end
        n_vec++; if (w_mosi !== 8'h55)        begin n_err++; $display("FAIL gap_mosi1: %02h, expected 55", w_mosi); end
        bad = 0; nrdy = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (cs !== 1'b0 || sck !== 1'b0) bad++;
            if (tx_ready !== 1'b1) nrdy++;
        end
        n_vec++; if (bad !== 0)  begin n_err++; $display("FAIL gap_stall_pins: %0d bad cycles, expected 0", bad); end
        n_vec++; if (nrdy !== 0) begin n_err++; $display("FAIL gap_stall_ready: %0d not-ready cycles, expected 0", nrdy); end
        send_byte(8'hAA, 1'b1, 8'hF0, 1'b0, t1);
        watch(40);
        n_vec++; if (w_rx_first - t1 !== 32)  begin n_err++; $display("FAIL gap_rx2_at: %0d, expected 32", w_rx_first - t1); end
        n_vec++; if (w_cs_rise - t1 !== 34)   begin n_err++; $display("FAIL gap_cs_rise: %0d, expected 34", w_cs_rise - t1); end
        n_vec++; if (w_rdy_rise - t1 !== 36)  begin n_err++; $display("FAIL gap_ready_at: %0d, expected 36", w_rdy_rise - t1); end
        n_vec++; if (w_mosi !== 8'hAA)        begin n_err++; $display("FAIL gap_mosi2: %02h, expected aa", w_mosi); end
    endtask

    task automatic test_div1;
        int t0;
        sel1 = 1'b1;
        sl_resp[0] = 8'h00;
        @(negedge clk);
        send_byte(8'hFF, 1'b1, 8'h00, 1'b0, t0);
        watch(25);
        n_vec++; if (w_rx_first - t0 !== 16)          begin n_err++; $display("FAIL div1_rx_at: %0d, expected 16", w_rx_first - t0); end
        n_vec++; if (w_rise_last - w_rise_first !== 14) begin n_err++; $display("FAIL div1_sck_span: %0d, expected 14", w_rise_last - w_rise_first); end
        n_vec++; if (w_rises !== 8)                   begin n_err++; $display("FAIL div1_rises: %0d, expected 8", w_rises); end
        n_vec++; if (w_mosi !== 8'hFF)                begin n_err++; $display("FAIL div1_mosi: %02h, expected ff", w_mosi); end
        n_vec++; if (w_rdy_rise - t0 !== 18)          begin n_err++; $display("FAIL div1_ready_at: %0d, expected 18", w_rdy_rise - t0); end
        sel1 = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_async_reset;
        int t0, t1;
        logic [7:0] dropped;
        sl_resp[0] = 8'h77;
        send_byte(8'hE7, 1'b1, 8'h77, 1'b0, t0);
        repeat (10) @(negedge clk);
        @(posedge clk);
        #1 nrst = 1'b0;
        #1;
        n_vec++; if ({cs, sck, mosi, busy} !== 4'b1000) begin n_err++; $display("FAIL arst_pins: cs/sck/mosi/busy=%b, expected 1000", {cs, sck, mosi, busy}); end
        dropped = exp_tx.pop_back();
        dropped = exp_rx.pop_back();
        @(negedge clk);
        fork
            watch(20);
            begin
                repeat (4) @(negedge clk);
                nrst = 1'b1;
            end
        join
        n_vec++; if (w_rx_cnt !== 0)   begin n_err++; $display("FAIL arst_no_rx: %0d pulses, expected 0", w_rx_cnt); end
        n_vec++; if (w_cs_falls !== 0) begin n_err++; $display("FAIL arst_cs_quiet: %0d falls, expected 0", w_cs_falls); end
        n_vec++; if ({rx_dat, busy, tx_ready} !== 10'b0000_0000_01) begin n_err++; $display("FAIL arst_after: rxdata/busy/rdy=%b, expected 0000000001", {rx_dat, busy, tx_ready}); end
        sl_resp[0] = 8'hC3;
        send_byte(8'h5A, 1'b1, 8'hC3, 1'b0, t1);
        watch(40);
        n_vec++; if (w_rx_first - t1 !== 32)  begin n_err++; $display("FAIL arst_fresh_rx_at: %0d, expected 32", w_rx_first - t1); end
        n_vec++; if (w_mosi !== 8'h5A)        begin n_err++; $display("FAIL arst_fresh_mosi: %02h, expected 5a", w_mosi); end
    endtask

    task automatic test_valid_ignored;
        int t0;
        int pulse_at[4] = '{6, 19, 32, 35};
        sl_resp[0] = 8'h5E;
        send_byte(8'hC3, 1'b1, 8'h5E, 1'b0, t0);
        fork
            watch(42);
            begin
                int cur;
                cur = 0;
                foreach (pulse_at[k]) begin
                    repeat (pulse_at[k] - cur) @(negedge clk);
                    tx_data = 8'h99; tx_last = 1'b0; tx_valid = 1'b1;
                    @(negedge clk);
                    tx_valid = 1'b0;
                    cur = pulse_at[k] + 1;
                end
            end
        join
        n_vec++; if (w_rises !== 8)          begin n_err++; $display("FAIL ign_rises: %0d, expected 8", w_rises); end
        n_vec++; if (w_mosi !== 8'hC3)       begin n_err++; $display("FAIL ign_mosi: %02h, expected c3", w_mosi); end
        n_vec++; if (w_rx_first - t0 !== 32) begin n_err++; $display("FAIL ign_rx_at: %0d, expected 32", w_rx_first - t0); end
        n_vec++; if (w_cs_rise - t0 !== 34)  begin n_err++; $display("FAIL ign_cs_rise: %0d, expected 34", w_cs_rise - t0); end
        n_vec++; if (w_rdy_rise - t0 !== 36) begin n_err++; $display("FAIL ign_ready_at: %0d, expected 36", w_rdy_rise - t0); end
        n_vec++; if (w_cs_falls !== 0)       begin n_err++; $display("FAIL ign_no_accept: %0d CS falls, expected 0", w_cs_falls); end
    endtask

    initial begin
        sl_resp[0] = 8'h00; sl_resp[1] = 8'h00; sl_resp[2] = 8'h00; sl_resp[3] = 8'h00;
        test_reset();
        test_single();
        test_back_to_back();
        test_gap_stall();
        test_div1();
        test_async_reset();
        test_valid_ignored();
        repeat (10) @(negedge clk);
        n_vec++;
        if (exp_tx.size() != 0 || exp_rx.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drain: %0d tx / %0d rx left, expected 0 / 0", exp_tx.size(), exp_rx.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/post_spi_master.md
Name: post_spi_master

Overview:
- SPI initiator (mode 0: CPOL=0, CPHA=0, MSB first, 8-bit frames) that drives the SCK/MOSI/CS pins of the Post-machine SPI target and captures its MISO.
- Used by the test/loader side to write programs into, and read state back from, the Post system.
- Byte-level valid/ready interface. CS is held asserted across consecutive bytes until a byte flagged LAST completes.

Parameters:
- CLK_DIV, 4, CLK cycles per SCK half-period; legal range ≥1.
- FRAME_W, 8, bits per frame; fixed at 8 for this release.

Ports:
- CLK  in  1  system clock; all logic on its rising edge.
- NRST  in  1  asynchronous, active-low reset.
- TX_DATA  in  8  byte to transmit; sampled on accept.
- TX_LAST  in  1  deassert CS after this byte; sampled on accept.
- TX_VALID  in  1  TX_DATA/TX_LAST valid.
- TX_READY  out  1  block can accept a byte; accept = TX_VALID & TX_READY at a CLK edge.
- RX_DATA  out  8  byte shifted in from MISO; stable until the next RX_VALID.
- RX_VALID  out  1  one-cycle pulse, RX_DATA new.
- BUSY  out  1  high whenever state ≠ IDLE.
- SPI_SCK  out  1  serial clock; idles low.
- SPI_MOSI  out  1  serial data to target.
- SPI_CS  out  1  chip select, active low.
- SPI_MISO  in  1  serial data from target.

Behaviour:
- Reset (async, NRST=0): state=IDLE, SPI_CS=1, SPI_SCK=0, SPI_MOSI=0, RX_DATA=0x00, RX_VALID=0, BUSY=0, TX_READY=1 (combinational from IDLE), bit counter=0, divider=0.
- Reset mid-frame: CS rises and SCK drops immediately (asynchronously). No RX_VALID is issued. The partial byte is discarded.
- States: IDLE, SHIFT, GAP (CS low, waiting for next byte), HOLD (CS-high setup), DESEL (min deselect).
- Timing notation: T0 = accept edge, D = CLK_DIV.
- At T0: shift reg←TX_DATA, last←TX_LAST, SPI_CS←0, SPI_MOSI←TX_DATA[7], SCK stays 0, state←SHIFT.
- Divider counts D cycles per half-period. SCK toggles at T0+k·D for k=1..16.
- Rising SCK edges occur at T0+(2j+1)·D, j=0..7. At each one, SPI_MISO is sampled and shifted into the RX shift reg (LSB in).
- Falling SCK edges occur at T0+2j·D, j=1..7. At each one, MOSI←next bit (b6..b0).
- Final falling edge at T0+16·D: SCK=0, RX_DATA←shift reg, RX_VALID=1 for exactly one cycle, MOSI←0.
  - last=0: state←GAP, TX_READY=1 from that cycle, CS stays 0. An accept in GAP behaves exactly as at T0 (new T0). GAP may last indefinitely.
  - last=1: state←HOLD for D cycles (CS low, SCK low). At T0+17·D CS←1, state←DESEL. After D more cycles (T0+18·D) state←IDLE, TX_READY=1.
- TX_READY=0 in SHIFT, HOLD and DESEL. TX_VALID is ignored there (not queued).
- Per-byte latency accept→RX_VALID = 16·D cycles. A single-byte transaction occupies 18·D cycles from accept to next-ready.
- Back-to-back bytes: the first bit of the next byte is presented at its accept edge. An SCK rising edge never occurs less than D cycles after a MOSI change.
- D=1: SCK = CLK/2. All rules above hold unchanged.
- TX_VALID held high with the same data continuously: the byte is re-accepted every time TX_READY rises. This is the intended streaming usage.

Decomposition:
- Package post_spi_pkg:
  - state enum (IDLE, SHIFT, GAP, HOLD, DESEL)
  - FRAME_W=8
  - CPOL=0, CPHA=0 constants
  - bit-counter width function clog2(FRAME_W*2)
- One sub-module, post_spi_tick: down-counter reloaded with CLK_DIV-1, emitting a one-cycle half-period tick while enabled and cleared on disable. The master FSM, shift registers and bit counter stay in post_spi_master.

Test Plan (CLK_DIV=2 unless stated; slave model is mode-0 and returns its programmed byte MSB first):
- Single byte: TX 0xA5, LAST=1, slave returns 0x3C.
  - MOSI bits on rising SCK = 1,0,1,0,0,1,0,1.
  - RX_VALID at T0+32 with RX_DATA=0x3C.
  - CS low on cycles T0+1..T0+34; TX_READY back at T0+36.
- Three-byte burst: 0x01, 0x02, 0x80 (LAST on the third), TX_VALID held high.
  - CS stays low from the first accept to HOLD end (single falling CS edge).
  - Exactly 24 SCK rising edges and three RX_VALID pulses.
- GAP stall: 0x55 with LAST=0, then TX_VALID low for 50 cycles, then 0xAA with LAST=1.
  - CS low and SCK low for all 50 stall cycles.
  - Second byte timing identical to the first-byte case.
- CLK_DIV=1: TX 0xFF, slave returns 0x00.
  - SCK period = 2 CLK cycles; RX_VALID at T0+16; RX_DATA=0x00.
- Async reset at T0+11 during a transfer.
  - Same cycle: CS=1, SCK=0, MOSI=0, BUSY=0.
  - No RX_VALID is seen.
  - After NRST release, a fresh 0x5A transfer completes correctly.
- TX_VALID pulsed during SHIFT/HOLD/DESEL: no accept, no corruption of the current byte, SCK edge count unchanged.
